// File: rtl/mano_io_pkg.sv
// Shared definitions for the Mano machine I/O terminal: character width
// and the output-path state encoding.
package mano_io_pkg;

  localparam int WORD_W = 8;

  typedef enum logic [1:0] {
    OUT_IDLE    = 2'd0,
    OUT_WAIT    = 2'd1,
    OUT_PRESENT = 2'd2
  } out_state_t;

endpackage

// File: rtl/mano_io_fifo.sv
// Synchronous FIFO buffering host characters ahead of INPR.
// Head is shown combinationally on dout; empty/full come from the registered count.
module mano_io_fifo
  import mano_io_pkg::*;
#(
  parameter int WORD_W = mano_io_pkg::WORD_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              push,
  input  logic [WORD_W-1:0] din,
  input  logic              pop,
  output logic [WORD_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Pointers are AW bits wide, so wrap modulo DEPTH falls out naturally.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/mano_io_terminal.sv
// Device side of the Mano machine I/O interface: keyboard FIFO feeding INPR/FGI,
// and an OUTR capture path that delays, presents to the host, then re-raises FGO.
module mano_io_terminal
  import mano_io_pkg::*;
#(
  parameter int WORD_W    = mano_io_pkg::WORD_W,
  parameter int DEPTH     = 4,
  parameter int OUT_DELAY = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [WORD_W-1:0] host_in_data,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  output logic [WORD_W-1:0] inpr,
  output logic              fgi,
  input  logic              cpu_inp_ack,
  input  logic [WORD_W-1:0] outr,
  input  logic              cpu_out_strobe,
  output logic              fgo,
  output logic [WORD_W-1:0] host_out_data,
  output logic              host_out_valid,
  input  logic              host_out_ready,
  output logic              overrun
);

  localparam int CNT_W = (OUT_DELAY > 1) ? $clog2(OUT_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (OUT_DELAY > 0) ? CNT_W'(OUT_DELAY - 1) : '0;

  logic [WORD_W-1:0] w_head;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_load;
  logic [WORD_W-1:0] r_inpr;
  logic              r_fgi;

  out_state_t        r_state;
  out_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [WORD_W-1:0] r_out_data;
  logic [WORD_W-1:0] w_out_data_nxt;
  logic              r_overrun;
  logic              w_overrun_nxt;

  assign w_push = host_in_valid & ~w_full;
  assign w_load = ~w_empty & (~r_fgi | cpu_inp_ack);

  mano_io_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (w_push),
    .din   (host_in_data),
    .pop   (w_load),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full)
  );

  // Empty is from the registered count, so a fresh push reaches INPR one edge later.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_inpr <= '0;
      r_fgi  <= 1'b0;
    end else if (w_load) begin
      r_inpr <= w_head;
      r_fgi  <= 1'b1;
    end else if (cpu_inp_ack & r_fgi) begin
      r_fgi  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= OUT_IDLE;
      r_cnt      <= '0;
      r_out_data <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_out_data <= w_out_data_nxt;
      r_overrun  <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_out_data_nxt = r_out_data;
    w_overrun_nxt  = r_overrun | (cpu_out_strobe & (r_state != OUT_IDLE));
    case (r_state)
      OUT_IDLE: begin
        if (cpu_out_strobe) begin
          w_out_data_nxt = outr;
          w_cnt_nxt      = CNT_INIT;
          w_state_nxt    = (OUT_DELAY == 0) ? OUT_PRESENT : OUT_WAIT;
        end
      end
      OUT_WAIT: begin
        if (r_cnt == '0) w_state_nxt = OUT_PRESENT;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      OUT_PRESENT: begin
        if (host_out_ready) w_state_nxt = OUT_IDLE;
      end
      default: w_state_nxt = OUT_IDLE;
    endcase
  end

  assign host_in_ready  = ~w_full;
  assign inpr           = r_inpr;
  assign fgi            = r_fgi;
  assign fgo            = (r_state == OUT_IDLE);
  assign host_out_data  = r_out_data;
  assign host_out_valid = (r_state == OUT_PRESENT);
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_mano_io_terminal.sv
// Bench for mano_io_terminal: directed scenarios then random traffic, each cycle
// compared against a queue-based behavioural model of the terminal.
module tb_mano_io_terminal;

  localparam int WORD_W    = 8;
  localparam int DEPTH     = 4;
  localparam int OUT_DELAY = 3;

  logic              clk = 1'b0;
  logic              clr;
  logic [WORD_W-1:0] host_in_data;
  logic              host_in_valid;
  logic              host_in_ready;
  logic [WORD_W-1:0] inpr;
  logic              fgi;
  logic              cpu_inp_ack;
  logic [WORD_W-1:0] outr;
  logic              cpu_out_strobe;
  logic              fgo;
  logic [WORD_W-1:0] host_out_data;
  logic              host_out_valid;
  logic              host_out_ready;
  logic              overrun;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [WORD_W-1:0] m_q[$];
  logic [WORD_W-1:0] m_inpr;
  logic              m_fgi;
  logic              m_busy;
  int                m_age;
  logic [WORD_W-1:0] m_odata;
  logic              m_ovr;

  always #5 clk = ~clk;

  mano_io_terminal #(
    .WORD_W    (WORD_W),
    .DEPTH     (DEPTH),
    .OUT_DELAY (OUT_DELAY)
  ) dut (
    .clk            (clk),
    .clr            (clr),
    .host_in_data   (host_in_data),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .inpr           (inpr),
    .fgi            (fgi),
    .cpu_inp_ack    (cpu_inp_ack),
    .outr           (outr),
    .cpu_out_strobe (cpu_out_strobe),
    .fgo            (fgo),
    .host_out_data  (host_out_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .overrun        (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_update();
    logic push;
    logic ld;
    logic pres;
    if (clr) begin
      m_q.delete();
      m_inpr  = '0;
      m_fgi   = 1'b0;
      m_busy  = 1'b0;
      m_age   = 0;
      m_odata = '0;
      m_ovr   = 1'b0;
    end else begin
      push = host_in_valid && (m_q.size() < DEPTH);
      ld   = (m_q.size() > 0) && (!m_fgi || cpu_inp_ack);
      if (ld) begin
        m_inpr = m_q.pop_front();
        m_fgi  = 1'b1;
      end else if (cpu_inp_ack) begin
        m_fgi = 1'b0;
      end
      if (push) m_q.push_back(host_in_data);
      pres = m_busy && (m_age >= OUT_DELAY);
      if (!m_busy) begin
        if (cpu_out_strobe) begin
          m_busy  = 1'b1;
          m_age   = 0;
          m_odata = outr;
        end
      end else begin
        if (cpu_out_strobe) m_ovr = 1'b1;
        if (pres && host_out_ready) m_busy = 1'b0;
        else if (m_age < OUT_DELAY) m_age++;
      end
    end
  endtask

  task automatic check_all();
    chk("host_in_ready",  host_in_ready,  m_q.size() < DEPTH);
    chk("inpr",           inpr,           m_inpr);
    chk("fgi",            fgi,            m_fgi);
    chk("fgo",            fgo,            !m_busy);
    chk("host_out_valid", host_out_valid, m_busy && (m_age >= OUT_DELAY));
    chk("host_out_data",  host_out_data,  m_odata);
    chk("overrun",        overrun,        m_ovr);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic idle_in();
    clr            = 1'b0;
    host_in_valid  = 1'b0;
    host_in_data   = '0;
    cpu_inp_ack    = 1'b0;
    cpu_out_strobe = 1'b0;
    outr           = '0;
  endtask

  initial begin
    idle_in();
    host_out_ready = 1'b1;

    // 1: reset
    clr = 1'b1;
    step();
    step();
    clr = 1'b0;
    chk("rst_fgi", fgi, 1'b0);
    chk("rst_fgo", fgo, 1'b1);
    chk("rst_inpr", inpr, 8'h00);
    chk("rst_ready", host_in_ready, 1'b1);
    chk("rst_valid", host_out_valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);

    // 2: single push, no bypass
    host_in_valid = 1'b1; host_in_data = 8'd7;
    step();
    chk("t2_no_bypass", fgi, 1'b0);
    idle_in();
    step();
    chk("t2_fgi", fgi, 1'b1);
    chk("t2_inpr", inpr, 8'd7);
    cpu_inp_ack = 1'b1;
    step();
    cpu_inp_ack = 1'b0;
    chk("t2_ack_clears", fgi, 1'b0);
    chk("t2_inpr_held", inpr, 8'd7);

    // 3: ordered delivery with acks
    for (int i = 0; i < 3; i++) begin
      host_in_valid = 1'b1; host_in_data = 8'h41 + 8'(i);
      step();
    end
    idle_in();
    chk("t3_first", inpr, 8'h41);
    cpu_inp_ack = 1'b1;
    step();
    chk("t3_second", inpr, 8'h42);
    step();
    chk("t3_third", inpr, 8'h43);
    chk("t3_fgi_held", fgi, 1'b1);
    step();
    cpu_inp_ack = 1'b0;
    chk("t3_fgi_drop", fgi, 1'b0);

    // 3b: fill until full
    for (int i = 0; i < 5; i++) begin
      host_in_valid = 1'b1; host_in_data = 8'h60 + 8'(i);
      step();
    end
    chk("t3_full", host_in_ready, 1'b0);
    host_in_data = 8'hEE;
    step();
    idle_in();
    cpu_inp_ack = 1'b1;
    step();
    cpu_inp_ack = 1'b0;
    chk("t3_pop_ready", host_in_ready, 1'b1);
    chk("t3_pop_inpr", inpr, 8'h61);
    for (int i = 0; i < 4; i++) begin
      cpu_inp_ack = 1'b1;
      step();
    end
    cpu_inp_ack = 1'b0;
    chk("t3_drained", fgi, 1'b0);
    chk("t3_last", inpr, 8'h64);

    // 4: output with delay
    host_out_ready = 1'b1;
    cpu_out_strobe = 1'b1; outr = 8'h5A;
    step();
    idle_in();
    chk("t4_fgo_low", fgo, 1'b0);
    step();
    step();
    chk("t4_not_yet", host_out_valid, 1'b0);
    step();
    chk("t4_valid", host_out_valid, 1'b1);
    chk("t4_data", host_out_data, 8'h5A);
    step();
    chk("t4_fgo_back", fgo, 1'b1);
    chk("t4_valid_drop", host_out_valid, 1'b0);

    // 5: overrun while busy
    host_out_ready = 1'b0;
    cpu_out_strobe = 1'b1; outr = 8'h5A;
    step();
    outr = 8'h11;
    step();
    idle_in();
    chk("t5_overrun", overrun, 1'b1);
    chk("t5_data_kept", host_out_data, 8'h5A);
    for (int i = 0; i < 4; i++) step();
    chk("t5_presenting", host_out_valid, 1'b1);
    host_out_ready = 1'b1;
    step();
    chk("t5_sticky", overrun, 1'b1);
    chk("t5_fgo", fgo, 1'b1);

    // 6: reset mid-transfer
    for (int i = 0; i < 3; i++) begin
      host_in_valid = 1'b1; host_in_data = 8'h30 + 8'(i);
      cpu_out_strobe = (i == 2); outr = 8'h77;
      step();
    end
    idle_in();
    chk("t6_wait", fgo, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t6_fgi", fgi, 1'b0);
    chk("t6_inpr", inpr, 8'h00);
    chk("t6_fgo", fgo, 1'b1);
    chk("t6_overrun", overrun, 1'b0);
    chk("t6_odata", host_out_data, 8'h00);
    step();
    chk("t6_discarded", fgi, 1'b0);
    host_in_valid = 1'b1; host_in_data = 8'd7;
    cpu_out_strobe = 1'b1; outr = 8'h5A;
    step();
    idle_in();
    step();
    chk("t6_reload", inpr, 8'd7);
    step();
    step();
    chk("t6_present", host_out_valid, 1'b1);
    chk("t6_pdata", host_out_data, 8'h5A);

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      clr            = ($urandom_range(0, 299) == 0);
      host_in_valid  = $urandom_range(0, 1) == 1;
      host_in_data   = 8'($urandom);
      cpu_inp_ack    = m_fgi && ($urandom_range(0, 3) == 0);
      cpu_out_strobe = ($urandom_range(0, 7) == 0);
      outr           = 8'($urandom);
      host_out_ready = $urandom_range(0, 1) == 1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
